// File: rtl/ym_bus_sequencer.sv
// ---------------------------------------------------------------------------
// ym_bus_sequencer
//
// Arbitrates PSG register accesses from two requesters and turns each granted
// access into the BDIR/BC phase sequence a ym2149 needs. There are two chips
// (a TurboSound pair). A full access runs ADDR, GAP1, XFER, GAP2, DONE. A read
// leaves XFER straight for DONE, because chip DO is combinational and the
// GAP1 ahead of it already keeps BDIR low between pulses.
//
// Optional feature: define YM_ADDR_CACHE_EN to add a per-chip address shadow.
// When the shadow is valid and matches the requested register, the access
// skips ADDR and GAP1 and goes IDLE -> XFER. With the macro undefined, every
// access runs the full sequence.
//
// Parameters:
//   PHASE_CYC   CLK cycles per bus phase (ADDR, GAP1, XFER, GAP2), 1..15
//
// Ports:
//   CLK, RESET_N         clock, synchronous active-low reset
//   Rn_REQ               request level, held until Rn_ACK   (n = 0 CPU, 1 player)
//   Rn_RNW               1 = read, 0 = write
//   Rn_CHIP              target chip
//   Rn_REG               PSG register number
//   Rn_WDATA             write data
//   Rn_ACK               one-cycle completion pulse
//   RDATA                last read result, valid from ACK
//   PSG_BDIR, PSG_BC     per-chip bus control, bit n drives chip n
//   PSG_DI               shared data bus to both chips
//   PSG0_DO, PSG1_DO     chip data outputs
//   BUSY                 high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module ym_bus_sequencer #(
    parameter int unsigned PHASE_CYC = 2
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       R0_REQ,
    input  logic       R0_RNW,
    input  logic       R0_CHIP,
    input  logic [3:0] R0_REG,
    input  logic [7:0] R0_WDATA,
    output logic       R0_ACK,
    input  logic       R1_REQ,
    input  logic       R1_RNW,
    input  logic       R1_CHIP,
    input  logic [3:0] R1_REG,
    input  logic [7:0] R1_WDATA,
    output logic       R1_ACK,
    output logic [7:0] RDATA,
    output logic [1:0] PSG_BDIR,
    output logic [1:0] PSG_BC,
    output logic [7:0] PSG_DI,
    input  logic [7:0] PSG0_DO,
    input  logic [7:0] PSG1_DO,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_GAP1,
        ST_XFER,
        ST_GAP2,
        ST_DONE
    } state_e;

    // The counter counts down from PHASE_CYC-1, so a phase ends when it reaches zero.
    localparam logic [3:0] CNT_LOAD = 4'(PHASE_CYC - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rr_q, rr_d;          // requester that wins when both are pending
    logic       owner_q, owner_d;    // requester being served
    logic       chip_q, chip_d;
    logic       rnw_q, rnw_d;
    logic [3:0] reg_q, reg_d;
    logic [7:0] wdata_q, wdata_d;
    logic [1:0] bdir_q, bdir_d;
    logic [1:0] bc_q, bc_d;
    logic [7:0] di_q, di_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;

    logic       phase_end;
    logic       grant_valid;
    logic       grant_id;
    logic       sel_rnw;
    logic       sel_chip;
    logic [3:0] sel_reg;
    logic [7:0] sel_wdata;
    logic       addr_hit;
    logic [1:0] chip_oh;

    assign phase_end = (cnt_q == 4'd0);

    // Round robin only matters on a tie; a lone requester is always granted.
    assign grant_valid = R0_REQ | R1_REQ;
    assign grant_id    = (R0_REQ & R1_REQ) ? rr_q : R1_REQ;
    assign sel_rnw     = grant_id ? R1_RNW   : R0_RNW;
    assign sel_chip    = grant_id ? R1_CHIP  : R0_CHIP;
    assign sel_reg     = grant_id ? R1_REG   : R0_REG;
    assign sel_wdata   = grant_id ? R1_WDATA : R0_WDATA;

`ifdef YM_ADDR_CACHE_EN
    logic [1:0][3:0] shadow_reg_q;
    logic [1:0]      shadow_vld_q;

    assign addr_hit = shadow_vld_q[sel_chip] && (shadow_reg_q[sel_chip] == sel_reg);

    // NOTE: only the valid bits need a reset; a register value is never used while its valid bit is clear.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            shadow_vld_q <= '0;
        end else if (state_q == ST_ADDR && phase_end) begin
            shadow_vld_q[chip_q] <= 1'b1;
            shadow_reg_q[chip_q] <= reg_q;
        end
    end
`else
    assign addr_hit = 1'b0;
`endif

    // Next state and next outputs. The bus pins are registered from the
    // next-state values, so they line up with state_q and are glitch-free.
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
        rr_d    = rr_q;
        owner_d = owner_q;
        chip_d  = chip_q;
        rnw_d   = rnw_q;
        reg_d   = reg_q;
        wdata_d = wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_id;
                    rr_d    = ~grant_id;
                    chip_d  = sel_chip;
                    rnw_d   = sel_rnw;
                    reg_d   = sel_reg;
                    wdata_d = sel_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = addr_hit ? ST_XFER : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (phase_end) begin
                    state_d = ST_GAP1;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_GAP1: begin
                if (phase_end) begin
                    state_d = ST_XFER;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_XFER: begin
                if (phase_end) begin
                    state_d = rnw_q ? ST_DONE : ST_GAP2;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_GAP2: begin
                if (phase_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        chip_oh = chip_d ? 2'b10 : 2'b01;
        bdir_d  = 2'b00;
        bc_d    = 2'b00;
        di_d    = di_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;

        unique case (state_d)
            ST_ADDR: begin
                bdir_d = chip_oh;
                bc_d   = chip_oh;
                di_d   = {4'h0, reg_d};
            end
            ST_XFER: begin
                if (!rnw_d) begin
                    bdir_d = chip_oh;
                    di_d   = wdata_d;
                end
            end
            ST_DONE: begin
                ack0_d = ~owner_d;
                ack1_d = owner_d;
            end
            default: ;
        endcase

        // Read data is taken on the last XFER cycle, so it is stable when ACK rises.
        rdata_d = rdata_q;
        if (state_q == ST_XFER && phase_end && rnw_q) begin
            rdata_d = chip_q ? PSG1_DO : PSG0_DO;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            chip_q  <= 1'b0;
            rnw_q   <= 1'b0;
            reg_q   <= 4'h0;
            wdata_q <= 8'h00;
            bdir_q  <= 2'b00;
            bc_q    <= 2'b00;
            di_q    <= 8'h00;
            rdata_q <= 8'h00;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            chip_q  <= chip_d;
            rnw_q   <= rnw_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
            bdir_q  <= bdir_d;
            bc_q    <= bc_d;
            di_q    <= di_d;
            rdata_q <= rdata_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    assign R0_ACK   = ack0_q;
    assign R1_ACK   = ack1_q;
    assign RDATA    = rdata_q;
    assign PSG_BDIR = bdir_q;
    assign PSG_BC   = bc_q;
    assign PSG_DI   = di_q;
    assign BUSY     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ym_bus_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ym_bus_sequencer
//
// Scoreboard bench for ym_bus_sequencer. The stimulus pushes each expected
// access into a queue when it presents that access. A monitor on the falling
// edge then checks every BDIR pulse against the access at the head of the
// queue, and pops and checks the head when an ACK appears. A second instance
// with PHASE_CYC=1 covers back-to-back spacing.
// ---------------------------------------------------------------------------
module tb_ym_bus_sequencer;

    localparam int P = 2;
`ifdef YM_ADDR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    typedef struct {
        int         id;
        bit         rnw;
        bit         chip;
        logic [3:0] rg;
        logic [7:0] wd;
        logic [7:0] rd;
        bit         hit;
    } item_t;

    logic       clk;
    logic       rst_n;
    logic       r0_req, r0_rnw, r0_chip, r0_ack;
    logic [3:0] r0_reg;
    logic [7:0] r0_wdata;
    logic       r1_req, r1_rnw, r1_chip, r1_ack;
    logic [3:0] r1_reg;
    logic [7:0] r1_wdata;
    logic [7:0] rdata;
    logic [1:0] bdir, bc;
    logic [7:0] di;
    logic [7:0] psg0_do, psg1_do;
    logic       busy;

    logic       p1_r0_req, p1_r0_ack, p1_r1_ack;
    logic [3:0] p1_r0_reg;
    logic [7:0] p1_rdata, p1_di;
    logic [1:0] p1_bdir, p1_bc;
    logic       p1_busy;

    item_t      sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    ym_bus_sequencer #(.PHASE_CYC(P)) u_dut (
        .CLK(clk), .RESET_N(rst_n),
        .R0_REQ(r0_req), .R0_RNW(r0_rnw), .R0_CHIP(r0_chip), .R0_REG(r0_reg),
        .R0_WDATA(r0_wdata), .R0_ACK(r0_ack),
        .R1_REQ(r1_req), .R1_RNW(r1_rnw), .R1_CHIP(r1_chip), .R1_REG(r1_reg),
        .R1_WDATA(r1_wdata), .R1_ACK(r1_ack),
        .RDATA(rdata), .PSG_BDIR(bdir), .PSG_BC(bc), .PSG_DI(di),
        .PSG0_DO(psg0_do), .PSG1_DO(psg1_do), .BUSY(busy)
    );

    ym_bus_sequencer #(.PHASE_CYC(1)) u_dut_p1 (
        .CLK(clk), .RESET_N(rst_n),
        .R0_REQ(p1_r0_req), .R0_RNW(1'b0), .R0_CHIP(1'b0), .R0_REG(p1_r0_reg),
        .R0_WDATA(8'h12), .R0_ACK(p1_r0_ack),
        .R1_REQ(1'b0), .R1_RNW(1'b0), .R1_CHIP(1'b0), .R1_REG(4'h0),
        .R1_WDATA(8'h00), .R1_ACK(p1_r1_ack),
        .RDATA(p1_rdata), .PSG_BDIR(p1_bdir), .PSG_BC(p1_bc), .PSG_DI(p1_di),
        .PSG0_DO(8'h00), .PSG1_DO(8'h00), .BUSY(p1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic item_t mk(input int id, input bit rnw, input bit chip, input logic [3:0] rg,
                                 input logic [7:0] wd, input logic [7:0] rd, input bit hit);
        item_t it;
        it.id = id; it.rnw = rnw; it.chip = chip; it.rg = rg; it.wd = wd; it.rd = rd; it.hit = hit;
        return it;
    endfunction

    // ------------------------------------------------------------------ monitor
    int         smp = 0;
    int         start_smp = 0;
    int         hi_cnt = 0;
    int         addr_seen = 0;
    int         data_seen = 0;
    bit         prev_hi = 1'b0;
    bit         prev_busy = 1'b0;
    bit         phase_addr = 1'b0;
    logic [7:0] last_rdata = 8'h00;

    always @(negedge clk) begin
        item_t      it;
        logic [1:0] exp_oh;
        smp++;
        if (!rst_n) begin
            hi_cnt     = 0;
            addr_seen  = 0;
            data_seen  = 0;
            prev_hi    = 1'b0;
            prev_busy  = 1'b0;
            last_rdata = 8'h00;
        end else begin
            if (busy && !prev_busy) start_smp = smp;

            if (bdir != 2'b00) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL bus_active_without_access: bdir=%b", bdir);
                end else begin
                    it     = sb_q[0];
                    exp_oh = it.chip ? 2'b10 : 2'b01;
                    if (!prev_hi) begin
                        hi_cnt     = 0;
                        phase_addr = (bc != 2'b00);
                        if (phase_addr) addr_seen++;
                        else            data_seen++;
                    end
                    hi_cnt++;
                    check("bdir_sel", 32'(bdir), 32'(exp_oh));
                    check("bc_phase", 32'(bc), 32'(phase_addr ? exp_oh : 2'b00));
                    check("di_phase", 32'(di), 32'(phase_addr ? {4'h0, it.rg} : it.wd));
                end
            end else begin
                check("bc_low", 32'(bc), 32'(0));
                if (prev_hi) check("bdir_width", 32'(hi_cnt), 32'(P));
            end

            if (r0_ack && r1_ack) begin
                n_tests++;
                n_fail++;
                $display("FAIL ack_both: r0_ack=1 r1_ack=1 required one at most");
            end else if (r0_ack || r1_ack) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ack: r0_ack=%0b r1_ack=%0b with no access pending", r0_ack, r1_ack);
                end else begin
                    it = sb_q.pop_front();
                    check("ack_id", 32'(r1_ack), 32'(it.id));
                    check("ack_latency", 32'(smp - start_smp),
                          32'(it.rnw ? (it.hit ? P : 3 * P) : (it.hit ? 2 * P : 4 * P)));
                    check("addr_phases", 32'(addr_seen), 32'(it.hit ? 0 : 1));
                    check("data_phases", 32'(data_seen), 32'(it.rnw ? 0 : 1));
                    if (it.rnw) last_rdata = it.rd;
                    check("rdata", 32'(rdata), 32'(last_rdata));
                end
                addr_seen = 0;
                data_seen = 0;
            end

            prev_hi   = (bdir != 2'b00);
            prev_busy = busy;
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic present(input item_t it);
        sb_q.push_back(it);
        if (it.id == 0) begin
            r0_rnw = it.rnw; r0_chip = it.chip; r0_reg = it.rg; r0_wdata = it.wd; r0_req = 1'b1;
        end else begin
            r1_rnw = it.rnw; r1_chip = it.chip; r1_reg = it.rg; r1_wdata = it.wd; r1_req = 1'b1;
        end
    endtask

    task automatic wait_ack(input int id, input string name);
        int n = 0;
        logic got;
        do begin
            @(posedge clk); #1;
            n++;
            got = (id == 0) ? r0_ack : r1_ack;
        end while (!got && n < 100);
        check({name, "_ack_seen"}, 32'(got), 32'(1));
    endtask

    task automatic single(input item_t it, input string name);
        present(it);
        wait_ack(it.id, name);
        if (it.id == 0) r0_req = 1'b0;
        else            r1_req = 1'b0;
        @(posedge clk); #1;
    endtask

    item_t r0_tab[3];
    item_t r1_tab[3];

    initial begin
        int i0, i1, acks, n, cyc, last, n_ack, adj;
        bit prev;

        rst_n = 1'b0;
        r0_req = 1'b0; r0_rnw = 1'b0; r0_chip = 1'b0; r0_reg = 4'h0; r0_wdata = 8'h00;
        r1_req = 1'b0; r1_rnw = 1'b0; r1_chip = 1'b0; r1_reg = 4'h0; r1_wdata = 8'h00;
        psg0_do = 8'h5A; psg1_do = 8'hA5;
        p1_r0_req = 1'b0; p1_r0_reg = 4'h5;

        repeat (3) @(posedge clk);
        #1;
        check("rst_bdir", 32'(bdir), 32'(0));
        check("rst_bc", 32'(bc), 32'(0));
        check("rst_di", 32'(di), 32'(0));
        check("rst_rdata", 32'(rdata), 32'(0));
        check("rst_acks", 32'({r0_ack, r1_ack}), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_p1_outputs", 32'({p1_bdir, p1_bc, p1_busy, p1_r0_ack, p1_r1_ack}), 32'(0));
        check("rst_p1_data", 32'({p1_rdata, p1_di}), 32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single accesses from idle. The second and third leave the round-robin pointer at 0.
        single(mk(0, 1'b0, 1'b0, 4'd7, 8'h38, 8'h00, 1'b0), "w_c0_r7");
        single(mk(1, 1'b1, 1'b1, 4'd14, 8'h00, 8'hA5, 1'b0), "r_c1_r14");
        psg0_do = 8'h3C;
        single(mk(1, 1'b1, 1'b0, 4'd2, 8'h00, 8'h3C, 1'b0), "r_c0_r2");

        // Both requesters start in the same cycle and then stay busy: strict alternation 0,1,0,1,0,1.
        r0_tab[0] = mk(0, 1'b0, 1'b0, 4'd8, 8'h11, 8'h00, 1'b0);
        r0_tab[1] = mk(0, 1'b0, 1'b1, 4'd9, 8'h22, 8'h00, 1'b0);
        r0_tab[2] = mk(0, 1'b1, 1'b0, 4'd8, 8'h00, 8'h3C, CACHE);
        r1_tab[0] = mk(1, 1'b0, 1'b1, 4'd1, 8'h44, 8'h00, 1'b0);
        r1_tab[1] = mk(1, 1'b1, 1'b1, 4'd1, 8'h00, 8'hA5, 1'b0);
        r1_tab[2] = mk(1, 1'b0, 1'b0, 4'd12, 8'h55, 8'h00, 1'b0);
        present(r0_tab[0]);
        present(r1_tab[0]);
        i0 = 1; i1 = 1; acks = 0; n = 0;
        while (acks < 6 && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (r0_ack) begin
                acks++;
                if (i0 < 3) begin present(r0_tab[i0]); i0++; end
                else r0_req = 1'b0;
            end
            if (r1_ack) begin
                acks++;
                if (i1 < 3) begin present(r1_tab[i1]); i1++; end
                else r1_req = 1'b0;
            end
        end
        check("alt_ack_count", 32'(acks), 32'(6));
        r0_req = 1'b0;
        r1_req = 1'b0;
        @(posedge clk); #1;

        // Repeated register on chip 0 (address phase skipped when cached), then the same register on chip 1.
        single(mk(0, 1'b0, 1'b0, 4'd13, 8'h66, 8'h00, 1'b0), "w_c0_r13_a");
        single(mk(0, 1'b0, 1'b0, 4'd13, 8'h77, 8'h00, CACHE), "w_c0_r13_b");
        single(mk(0, 1'b0, 1'b0 ^ 1'b1, 4'd13, 8'h88, 8'h00, 1'b0), "w_c1_r13");

        // Reset in the middle of the data phase aborts the access without an ACK.
        present(mk(0, 1'b0, 1'b0, 4'd13, 8'h99, 8'h00, CACHE));
        n = 0;
        while (!(bdir[0] && !bc[0]) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_data_phase_seen", 32'(bdir[0] && !bc[0]), 32'(1));
        rst_n = 1'b0;
        r0_req = 1'b0;
        sb_q.delete();
        @(posedge clk); #1;
        check("abort_bus", 32'({bdir, bc}), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_ack", 32'({r0_ack, r1_ack}), 32'(0));
        check("abort_di_rdata", 32'({di, rdata}), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_late_ack", 32'({r0_ack, r1_ack}), 32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        single(mk(0, 1'b0, 1'b0, 4'd13, 8'h99, 8'h00, 1'b0), "w_after_reset");

        // PHASE_CYC=1, request held: an ACK every 6 cycles, and BDIR never high twice in a row.
        // The register alternates so that a cached build still runs the full sequence.
        p1_r0_reg = 4'h5;
        p1_r0_req = 1'b1;
        cyc = 0; last = 0; n_ack = 0; adj = 0; prev = 1'b0;
        while (n_ack < 4 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (p1_bdir != 2'b00 && prev) adj++;
            prev = (p1_bdir != 2'b00);
            if (p1_r0_ack) begin
                if (n_ack == 0) check("p1_first_ack", 32'(cyc), 32'(5));
                else            check("p1_ack_spacing", 32'(cyc - last), 32'(6));
                last = cyc;
                n_ack++;
                p1_r0_reg = (p1_r0_reg == 4'h5) ? 4'h6 : 4'h5;
                if (n_ack == 4) p1_r0_req = 1'b0;
            end
        end
        check("p1_ack_count", 32'(n_ack), 32'(4));
        check("p1_bdir_adjacent", 32'(adj), 32'(0));
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ym_bus_sequencer.md
Name: ym_bus_sequencer

Overview:
- Arbitrates PSG register accesses from two requesters: the CPU port decoder (requester 0) and the replay/player engine (requester 1).
- Targets two ym2149 instances in a TurboSound pair.
- Turns each granted access into the BDIR/BC phase sequence the PSG needs: address latch, gap, data write or read, gap. The PSG latches on the BDIR rising edge, so every access returns BDIR low between phases.
- Sits between the port/player logic and the PSG bus pins, on the PSG clock domain (CLK).

Parameters:
- PHASE_CYC, 2, CLK cycles per bus phase (ADDR, GAP1, DATA/READ, GAP2). Legal range 1..15.

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  synchronous reset, active low
- R0_REQ  in  1  requester 0 (CPU) access request; level, held until R0_ACK
- R0_RNW  in  1  1 = read, 0 = write
- R0_CHIP  in  1  target PSG, 0 or 1
- R0_REG  in  4  PSG register number
- R0_WDATA  in  8  write data
- R0_ACK  out  1  one-cycle completion pulse
- R1_REQ, R1_RNW, R1_CHIP, R1_REG, R1_WDATA, R1_ACK  same as R0_*, for requester 1 (player)
- RDATA  out  8  read result; valid from ACK, held until the next read completes
- PSG_BDIR  out  2  per-chip BDIR; bit n drives chip n
- PSG_BC  out  2  per-chip BC
- PSG_DI  out  8  shared data bus to both chips
- PSG0_DO  in  8  chip 0 DO
- PSG1_DO  in  8  chip 1 DO
- BUSY  out  1  high whenever state is not IDLE

Behaviour:
- Reset (RESET_N=0 at a CLK edge), even mid-sequence:
  - state goes to IDLE, phase counter to 0
  - PSG_BDIR=0, PSG_BC=0, PSG_DI=0, RDATA=0
  - both ACKs 0, BUSY 0, round-robin pointer to 0, address shadows invalid
  - an aborted access is never acknowledged
- States: IDLE, ADDR, GAP1, XFER, GAP2, DONE.
- Each of ADDR/GAP1/XFER/GAP2 lasts exactly PHASE_CYC cycles; DONE lasts 1 cycle.
- Arbitration, evaluated only in IDLE:
  - one requester pending: grant it
  - both pending: grant the one not served last (round-robin), then flip the pointer
  - on grant, chip/reg/rnw/wdata are captured into internal registers; later changes to requester inputs are ignored
- Phase outputs; only the selected chip's bit is ever nonzero, the other chip's BDIR/BC stay 0:
  - ADDR: BDIR=1, BC=1, PSG_DI={4'b0, reg}
  - GAP1: BDIR=0, BC=0
  - XFER write: BDIR=1, BC=0, PSG_DI=wdata
  - XFER read: BDIR=0, BC=0; the selected chip's DO is sampled into RDATA on the last XFER cycle
  - GAP2: BDIR=0, BC=0
  - DONE: the granted requester's ACK=1, then IDLE
- Transitions:
  - IDLE→ADDR the cycle after grant, or IDLE→XFER on a shadow hit (see Optional Feature)
  - ADDR→GAP1→XFER
  - XFER→GAP2 for writes; XFER→DONE for reads, since DO is combinational and needs no trailing gap
  - GAP2→DONE→IDLE
- Latency, with P=PHASE_CYC and grant sampled at cycle t:
  - write, full sequence: ACK at t+4P+1
  - read, full sequence: ACK at t+3P+1
- Request protocol:
  - a requester must deassert REQ, or present a new access, in the cycle after ACK
  - REQ still high in the IDLE cycle after DONE is treated as a new request
- Address shadow: per chip, 4-bit register plus valid bit.
  - updated at the end of every ADDR phase
  - invalidated only by reset
- PSG_DI holds its last driven value during GAP and IDLE phases.
- PHASE_CYC counter is 4 bits wide and reloads on every phase entry.
- Back-to-back accesses are guaranteed at least P cycles of BDIR low between BDIR high phases on the same chip, via GAP2, or GAP1 for reads.

Optional Feature:
- Macro: YM_ADDR_CACHE_EN.
- Defined: on grant, if the target chip's shadow is valid and equals reg, skip ADDR and GAP1 and go IDLE→XFER directly.
  - write ACK at t+2P+1
  - read ACK at t+P+1
- Undefined: the shadow logic is absent and every access runs the full sequence. All other behaviour is identical.

Test Plan:
- P=2, requester 0 writes chip0 reg7 = 0x38 from reset:
  - PSG_BDIR[0]=1, BC[0]=1, DI=0x07 for 2 cycles; 2 low
  - then BDIR=1, BC=0, DI=0x38 for 2 cycles; 2 low
  - R0_ACK at t+9; PSG_BDIR[1] stays 0 throughout
- P=2, requester 1 reads chip1 reg14 with PSG1_DO=0xA5:
  - R1_ACK at t+7 and RDATA=0xA5
  - PSG0_DO value ignored
- Both REQ rise in the same cycle, pointer=0:
  - requester 0 served first, requester 1 next
  - with both then held, strict alternation over 4 accesses
- Macro defined: two consecutive writes to chip0 reg13:
  - second has no ADDR phase, ACK at t+5
  - a following write to chip1 reg13 still runs ADDR, since shadows are per chip
- RESET_N low during the DATA phase:
  - next cycle all BDIR/BC=0, BUSY=0, no ACK
  - after release, the same write re-runs the full ADDR sequence even with the macro defined
- P=1, a write with R0_REQ held continuously:
  - ACK every 6 cycles
  - BDIR never high in two adjacent cycles across the access boundary
